// File: rtl/updown_preload_counter.sv
// Free-running WIDTH-bit up/down counter with synchronous parallel preload.
// Async active-high reset clears the count; qout comes straight from the state register.
module updown_preload_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             preload,
  input  logic             up_dn,
  input  logic [WIDTH-1:0] pl_data,
  output logic [WIDTH-1:0] qout
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Preload wins over counting; arithmetic wraps modulo 2^WIDTH.
  always_comb begin
    count_d = count_q;
    if (preload) begin
      count_d = pl_data;
    end else if (up_dn) begin
      count_d = count_q + WIDTH'(1);
    end else begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign qout = count_q;

endmodule

// File: tb/tb_updown_preload_counter.sv
// Directed self-checking bench for updown_preload_counter.
module tb_updown_preload_counter;

  localparam int unsigned WIDTH = 8;

  logic             clk;
  logic             reset;
  logic             preload;
  logic             up_dn;
  logic [WIDTH-1:0] pl_data;
  logic [WIDTH-1:0] qout;

  int checks;
  int errors;

  updown_preload_counter #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .reset   (reset),
    .preload (preload),
    .up_dn   (up_dn),
    .pl_data (pl_data),
    .qout    (qout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    preload = 1'b0;
    up_dn   = 1'b1;
    pl_data = 8'd0;
    #1;
    checks++;
    if (qout !== 8'd0) begin
      errors++;
      $display("FAIL reset_initial: got %0d expected 0", qout);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (qout !== 8'd0) begin
        errors++;
        $display("FAIL reset_hold edge %0d: got %0d expected 0", i, qout);
      end
    end
    // Count to 3, then assert reset between edges.
    reset = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step();
      checks++;
      if (qout !== 8'(i)) begin
        errors++;
        $display("FAIL reset_precount %0d: got %0d expected %0d", i, qout, i);
      end
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (qout !== 8'd0) begin
      errors++;
      $display("FAIL reset_async: got %0d expected 0", qout);
    end
    step();
    checks++;
    if (qout !== 8'd0) begin
      errors++;
      $display("FAIL reset_async_hold: got %0d expected 0", qout);
    end
  endtask

  task automatic test_count_up();
    reset = 1'b0;
    up_dn = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      step();
      checks++;
      if (qout !== 8'(i)) begin
        errors++;
        $display("FAIL count_up %0d: got %0d expected %0d", i, qout, i);
      end
    end
  endtask

  task automatic test_preload();
    preload = 1'b1;
    pl_data = 8'd50;
    step();
    checks++;
    if (qout !== 8'd50) begin
      errors++;
      $display("FAIL preload_50: got %0d expected 50", qout);
    end
    preload = 1'b0;
    pl_data = 8'd0;
    for (int i = 1; i <= 30; i++) begin
      step();
      checks++;
      if (qout !== 8'(50 + i)) begin
        errors++;
        $display("FAIL preload_count_up %0d: got %0d expected %0d", i, qout, 50 + i);
      end
    end
  endtask

  task automatic test_count_down();
    up_dn = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      step();
      checks++;
      if (qout !== 8'(80 - i)) begin
        errors++;
        $display("FAIL count_down %0d: got %0d expected %0d", i, qout, 80 - i);
      end
    end
  endtask

  task automatic test_wrap();
    logic [WIDTH-1:0] exp_seq [3];
    exp_seq[0] = 8'd255;
    exp_seq[1] = 8'd0;
    exp_seq[2] = 8'd1;

    preload = 1'b1; pl_data = 8'd255; up_dn = 1'b1;
    step();
    checks++;
    if (qout !== 8'd255) begin
      errors++;
      $display("FAIL wrap_load255: got %0d expected 255", qout);
    end
    preload = 1'b0;
    step();
    checks++;
    if (qout !== 8'd0) begin
      errors++;
      $display("FAIL wrap_up: got %0d expected 0", qout);
    end

    preload = 1'b1; pl_data = 8'd0; up_dn = 1'b0;
    step();
    checks++;
    if (qout !== 8'd0) begin
      errors++;
      $display("FAIL wrap_load0: got %0d expected 0", qout);
    end
    preload = 1'b0;
    step();
    checks++;
    if (qout !== 8'd255) begin
      errors++;
      $display("FAIL wrap_down: got %0d expected 255", qout);
    end

    preload = 1'b1; pl_data = 8'd254; up_dn = 1'b1;
    step();
    checks++;
    if (qout !== 8'd254) begin
      errors++;
      $display("FAIL wrap_load254: got %0d expected 254", qout);
    end
    preload = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (qout !== exp_seq[i]) begin
        errors++;
        $display("FAIL wrap_seq %0d: got %0d expected %0d", i, qout, exp_seq[i]);
      end
    end
  endtask

  task automatic test_priority();
    preload = 1'b1; pl_data = 8'd7; up_dn = 1'b0;
    step();
    checks++;
    if (qout !== 8'd7) begin
      errors++;
      $display("FAIL priority_load7: got %0d expected 7", qout);
    end
    // Reset overrides an active preload, asynchronously.
    pl_data = 8'd99;
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (qout !== 8'd0) begin
      errors++;
      $display("FAIL priority_reset_async: got %0d expected 0", qout);
    end
    step();
    checks++;
    if (qout !== 8'd0) begin
      errors++;
      $display("FAIL priority_reset_hold: got %0d expected 0", qout);
    end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] exp_seq [5];
    logic             dir_seq [5];
    dir_seq[0] = 1'b1; exp_seq[0] = 8'd1;
    dir_seq[1] = 1'b0; exp_seq[1] = 8'd0;
    dir_seq[2] = 1'b0; exp_seq[2] = 8'd255;
    dir_seq[3] = 1'b1; exp_seq[3] = 8'd0;
    dir_seq[4] = 1'b1; exp_seq[4] = 8'd1;
    reset   = 1'b0;
    preload = 1'b0;
    pl_data = 8'd0;
    for (int i = 0; i < 5; i++) begin
      up_dn = dir_seq[i];
      step();
      checks++;
      if (qout !== exp_seq[i]) begin
        errors++;
        $display("FAIL back_to_back %0d: got %0d expected %0d", i, qout, exp_seq[i]);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_count_up();
    test_preload();
    test_count_down();
    test_wrap();
    test_priority();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
